// File: rtl/sim_ctrl_sequencer.sv
// sim_ctrl_sequencer
// Testbench-side controller that sequences the simulated SoC top. It holds the
// DUT in reset for a programmed number of cycles, then runs the one-shot DPI
// init handshake. After that it issues per-cycle DPI step requests until a
// halt arrives. It counts committed steps and schedules perf clean/dump
// pulses. It also buffers host UART input characters for the DUT to read.
//
// Ports:
//   clock, reset       clock and synchronous active-low reset
//   dut_reset          active-high reset driven into the DUT
//   init_req/init_ack  one-shot DPI init handshake
//   step_req/step_ack  per-cycle DPI step handshake (ack = step committed)
//   halt / halted      stop request in, terminal-state indication out
//   cycle_cnt          64-bit committed-step counter
//   perf_clean/dump    single-cycle perf pulses into the DUT
//   uart_push(_ch)     host pushes a character into the input FIFO
//   uart_full/ovf      FIFO full, sticky dropped-push flag
//   uart_rd/uart_rd_ch DUT read request and the character it sees
module sim_ctrl_sequencer #(
  parameter int unsigned RESET_CYCLES  = 100,
  parameter int unsigned PERF_INTERVAL = 1000000,
  parameter int unsigned UART_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        dut_reset,
  output logic        init_req,
  input  logic        init_ack,
  output logic        step_req,
  input  logic        step_ack,
  input  logic        halt,
  output logic        halted,
  output logic [63:0] cycle_cnt,
  output logic        perf_clean,
  output logic        perf_dump,
  input  logic        uart_push,
  input  logic [7:0]  uart_push_ch,
  output logic        uart_full,
  output logic        uart_ovf,
  input  logic        uart_rd,
  output logic [7:0]  uart_rd_ch
);

  localparam int AW = $clog2(UART_DEPTH);

  typedef enum logic [1:0] {
    RST_HOLD,
    INIT,
    RUN,
    HALTED
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] hold_cnt;
  logic        halt_pend;
  logic [31:0] perf_cnt;
  logic        step_count_en;

  logic [7:0]  fifo_mem [UART_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fifo_count;
  logic        fifo_empty;
  logic        pop;
  logic        push;

  // A halt seen before RUN is remembered so the first RUN cycle goes straight
  // to HALTED without committing any step.
  always_comb begin
    next_state    = state;
    step_count_en = 1'b0;
    case (state)
      RST_HOLD: if (hold_cnt == RESET_CYCLES - 1) next_state = INIT;
      INIT:     if (init_ack) next_state = RUN;
      RUN: begin
        step_count_en = step_ack && !halt_pend;
        if (halt || halt_pend) next_state = HALTED;
      end
      HALTED:   next_state = HALTED;
      default:  next_state = RST_HOLD;
    endcase
  end

  // Control outputs are registered off the next state so they line up with
  // the state they describe without decode glitches. The perf modulo counter
  // replaces a divide of the 64-bit step count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RST_HOLD;
      hold_cnt   <= 32'd0;
      halt_pend  <= 1'b0;
      dut_reset  <= 1'b1;
      init_req   <= 1'b0;
      step_req   <= 1'b0;
      halted     <= 1'b0;
      cycle_cnt  <= 64'd0;
      perf_cnt   <= 32'd0;
      perf_clean <= 1'b0;
      perf_dump  <= 1'b0;
    end else begin
      state      <= next_state;
      dut_reset  <= (next_state == RST_HOLD);
      init_req   <= (next_state == INIT);
      step_req   <= (next_state == RUN);
      halted     <= (next_state == HALTED);
      perf_clean <= (state == INIT) && (next_state == RUN);
      perf_dump  <= 1'b0;
      if (state == RST_HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (((state == RST_HOLD) || (state == INIT)) && halt) halt_pend <= 1'b1;
      if (step_count_en) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        if (perf_cnt == PERF_INTERVAL - 1) begin
          perf_cnt  <= 32'd0;
          perf_dump <= 1'b1;
        end else begin
          perf_cnt <= perf_cnt + 32'd1;
        end
      end
    end
  end

  // The pointers carry one extra wrap bit, so the occupancy is their
  // difference. Full is exactly the top bit of that difference, because the
  // occupancy never exceeds the power-of-two depth.
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign uart_full  = fifo_count[AW];
  assign pop        = uart_rd && !fifo_empty && (state != RST_HOLD);
  assign push       = uart_push && (!uart_full || pop);
  assign uart_rd_ch = fifo_empty ? 8'hff : fifo_mem[rd_ptr[AW-1:0]];

  // Pointer and overflow state. A push into a full FIFO is still accepted
  // when a pop frees the head slot in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      uart_ovf <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (uart_push && !push) uart_ovf <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= uart_push_ch;
  end

endmodule

// File: tb/tb_sim_ctrl_sequencer.sv
// Self-checking bench for sim_ctrl_sequencer. It uses small parameters so that
// the reset hold, perf scheduling and FIFO boundaries are all reached quickly.
module tb_sim_ctrl_sequencer;

  localparam int unsigned RC    = 4;
  localparam int unsigned PI    = 3;
  localparam int unsigned DEPTH = 4;
  localparam logic [14:0] ACK_PAT = 15'b010110111011011;

  logic        clock;
  logic        reset;
  logic        dut_reset;
  logic        init_req;
  logic        init_ack;
  logic        step_req;
  logic        step_ack;
  logic        halt;
  logic        halted;
  logic [63:0] cycle_cnt;
  logic        perf_clean;
  logic        perf_dump;
  logic        uart_push;
  logic [7:0]  uart_push_ch;
  logic        uart_full;
  logic        uart_ovf;
  logic        uart_rd;
  logic [7:0]  uart_rd_ch;

  int compared;
  int mismatched;
  int dump_seen;

  sim_ctrl_sequencer #(
    .RESET_CYCLES (RC),
    .PERF_INTERVAL(PI),
    .UART_DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dut_reset   (dut_reset),
    .init_req    (init_req),
    .init_ack    (init_ack),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .halt        (halt),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .perf_clean  (perf_clean),
    .perf_dump   (perf_dump),
    .uart_push   (uart_push),
    .uart_push_ch(uart_push_ch),
    .uart_full   (uart_full),
    .uart_ovf    (uart_ovf),
    .uart_rd     (uart_rd),
    .uart_rd_ch  (uart_rd_ch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model. It tracks how many edges have passed since reset,
  // whether init has completed, whether a halt has taken effect, the step
  // count, and the FIFO contents as a queue.
  int               m_edges;
  bit               m_inited;
  bit               m_halted;
  bit               m_pend;
  bit               m_clean;
  bit               m_dump;
  bit               m_ovf;
  bit               m_valid;
  longint unsigned  m_cnt;
  logic [7:0]       m_fifo [$];

  always @(posedge clock) begin
    bit in_hold;
    bit in_init;
    bit in_run;
    bit do_pop;
    if (!reset) begin
      m_valid  = 1'b1;
      m_edges  = 0;
      m_inited = 1'b0;
      m_halted = 1'b0;
      m_pend   = 1'b0;
      m_clean  = 1'b0;
      m_dump   = 1'b0;
      m_ovf    = 1'b0;
      m_cnt    = 0;
      m_fifo.delete();
    end else if (m_valid) begin
      in_hold = (m_edges < RC);
      in_init = !in_hold && !m_inited;
      in_run  = m_inited && !m_halted;
      do_pop  = uart_rd && (m_fifo.size() > 0) && !in_hold;
      if (do_pop) void'(m_fifo.pop_front());
      if (uart_push) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(uart_push_ch);
        else m_ovf = 1'b1;
      end
      m_clean = 1'b0;
      m_dump  = 1'b0;
      if (in_hold) begin
        m_edges++;
        if (halt) m_pend = 1'b1;
      end else if (in_init) begin
        if (halt) m_pend = 1'b1;
        if (init_ack) begin
          m_inited = 1'b1;
          m_clean  = 1'b1;
        end
      end else if (in_run) begin
        if (step_ack && !m_pend) begin
          m_cnt++;
          if (m_cnt % PI == 0) m_dump = 1'b1;
        end
        if (halt || m_pend) m_halted = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    if (m_valid) begin
      checkOutput("dut_reset", dut_reset, m_edges < RC);
      checkOutput("init_req", init_req, (m_edges >= RC) && !m_inited);
      checkOutput("step_req", step_req, m_inited && !m_halted);
      checkOutput("halted", halted, m_halted);
      checkOutput("cycle_cnt", cycle_cnt, m_cnt);
      checkOutput("perf_clean", perf_clean, m_clean);
      checkOutput("perf_dump", perf_dump, m_dump);
      checkOutput("uart_full", uart_full, m_fifo.size() == DEPTH);
      checkOutput("uart_ovf", uart_ovf, m_ovf);
      checkOutput("uart_rd_ch", uart_rd_ch, (m_fifo.size() > 0) ? m_fifo[0] : 8'hff);
    end
  end

  always @(negedge clock) if (perf_dump) dump_seen++;

  // Drive one cycle's worth of inputs on the falling edge.
  task automatic applyStimulus(input logic push, input logic [7:0] ch, input logic rd,
                               input logic sack, input logic iack, input logic hlt);
    @(negedge clock);
    uart_push    = push;
    uart_push_ch = ch;
    uart_rd      = rd;
    step_ack     = sack;
    init_ack     = iack;
    halt         = hlt;
  endtask

  // Wait out the reset hold, then complete init on the third INIT cycle.
  task automatic bringUp(input logic hlt);
    for (int i = 0; i < 20 && !init_req; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("bringup_init_req", init_req, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, hlt);
    applyStimulus(0, 8'h00, 0, 0, 1, hlt);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi;
    int base;
    compared     = 0;
    mismatched   = 0;
    dump_seen    = 0;
    reset        = 1'b0;
    init_ack     = 1'b0;
    step_ack     = 1'b0;
    halt         = 1'b0;
    uart_push    = 1'b0;
    uart_push_ch = 8'h00;
    uart_rd      = 1'b0;

    // Reset hold length and the init handshake.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    checkOutput("reset_cycle_cnt", cycle_cnt, 0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (dut_reset) hi++;
      if (init_req) break;
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
    end
    checkOutput("dut_reset_cycles", hi, 4);
    checkOutput("init_req_up", init_req, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("first_run_clean", perf_clean, 1);
    checkOutput("first_run_step_req", step_req, 1);

    // Irregular steps, halt on the last acknowledged one, then ignored acks.
    base = dump_seen;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 8'h00, 0, ACK_PAT[i], 0, i == 13);
      if (i == 0) checkOutput("clean_single_pulse", perf_clean, 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("steps_after_halt", cycle_cnt, 10);
    checkOutput("halted_set", halted, 1);
    checkOutput("halted_step_req", step_req, 0);
    checkOutput("dumps_irregular", dump_seen - base, 3);
    repeat (3) applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("cnt_frozen", cycle_cnt, 10);

    // Overfill the FIFO, then drain past empty.
    for (int k = 0; k < 5; k++) applyStimulus(1, 8'(8'h61 + k), 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("fifo_full", uart_full, 1);
    checkOutput("fifo_ovf", uart_ovf, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
      checkOutput("fifo_read", uart_rd_ch, (k < 4) ? 8'(8'h61 + k) : 8'hff);
    end
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("fifo_empty_ch", uart_rd_ch, 8'hff);
    checkOutput("fifo_not_full", uart_full, 0);

    // Full FIFO with simultaneous push and read.
    for (int k = 0; k < 4; k++) applyStimulus(1, 8'(8'h70 + k), 0, 0, 0, 0);
    applyStimulus(1, 8'h7a, 1, 0, 0, 0);
    checkOutput("pushpop_head", uart_rd_ch, 8'h70);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("pushpop_full", uart_full, 1);
    checkOutput("pushpop_next", uart_rd_ch, 8'h71);

    // Fresh run with continuous steps to exercise perf_dump spacing.
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    bringUp(0);
    base = dump_seen;
    for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("cont_steps", cycle_cnt, 10);
    checkOutput("dumps_continuous", dump_seen - base, 3);
    for (int i = 0; i < 47; i++)
      applyStimulus(i >= 45, (i == 45) ? 8'h78 : 8'h79, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("cnt_57", cycle_cnt, 57);
    checkOutput("queued_head", uart_rd_ch, 8'h78);

    // Reset mid-RUN, then a halt raised during INIT.
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("midrst_dut_reset", dut_reset, 1);
    checkOutput("midrst_cnt", cycle_cnt, 0);
    checkOutput("midrst_rd_ch", uart_rd_ch, 8'hff);
    checkOutput("midrst_step_req", step_req, 0);
    reset = 1'b1;
    bringUp(1);
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    checkOutput("pend_clean", perf_clean, 1);
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    checkOutput("pend_halted", halted, 1);
    checkOutput("pend_cnt", cycle_cnt, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sim_ctrl_sequencer.md
Name: sim_ctrl_sequencer

Overview:
Testbench-side controller that sequences the simulated SoC top:
- holds DUT reset for a programmed number of cycles;
- runs the one-shot DPI init handshake, then per-cycle DPI step handshakes until halt;
- keeps the committed-step counter and schedules perf clean/dump pulses;
- buffers host-supplied UART input characters and serves them to the DUT's UART read requests.

Parameters:
RESET_CYCLES, 100, cycles dut_reset is held high after controller reset release (>=1)
PERF_INTERVAL, 1000000, steps between perf_dump pulses (>=1, fits 32 bits)
UART_DEPTH, 8, UART input FIFO entries (power of 2, >=2)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low
dut_reset  out  1  active-high reset to DUT
init_req  out  1  request DPI init
init_ack  in  1  init done
step_req  out  1  request one DPI step
step_ack  in  1  step accepted this cycle
halt  in  1  stop request (good/bad trap, max cycles)
halted  out  1  sequencer in HALTED
cycle_cnt  out  64  committed steps
perf_clean  out  1  to DUT io_perfInfo_clean
perf_dump  out  1  to DUT io_perfInfo_dump
uart_push  in  1  host pushes a char
uart_push_ch  in  8  pushed char
uart_full  out  1  FIFO full
uart_ovf  out  1  sticky: push dropped
uart_rd  in  1  DUT io_uart_in_valid (read request)
uart_rd_ch  out  8  DUT io_uart_in_ch

Behaviour:
- Reset: already decided — reset reset, synchronous, active-low; clock clock.
- While reset=0 at a clock edge, next state is:
  - RST_HOLD, hold counter 0;
  - dut_reset=1; init_req=0, step_req=0, halted=0;
  - cycle_cnt=0; perf_clean=0, perf_dump=0;
  - FIFO empty; uart_full=0, uart_ovf=0.
- Reset mid-operation aborts any handshake and flushes the FIFO; no pending request survives.
- States: RST_HOLD -> INIT -> RUN -> HALTED.
- RST_HOLD:
  - dut_reset=1; counter increments each cycle.
  - When counter == RESET_CYCLES-1: next state INIT, dut_reset=0 from that edge.
  - Result: dut_reset is high for exactly RESET_CYCLES cycles after reset rises.
- INIT:
  - init_req=1 (Moore, registered state); waits indefinitely.
  - On init_ack=1: next state RUN.
  - init_ack outside INIT is ignored.
- RUN:
  - step_req=1 every cycle; each cycle with step_ack=1 increments cycle_cnt by 1 (64-bit wrap allowed, no saturation).
  - perf_clean: one-cycle pulse on the first cycle in RUN.
  - perf_dump: one-cycle pulse in the cycle after cycle_cnt becomes a nonzero multiple of PERF_INTERVAL. Use a 32-bit modulo counter, not a divide.
  - halt=1: next state HALTED. step_ack in that same cycle still counts; halt has priority over continuing.
- HALTED: terminal until reset. halted=1, step_req=0; step_ack ignored; cycle_cnt frozen.
- halt in RST_HOLD or INIT is latched and takes effect on the first RUN cycle. No steps are counted after the latch; perf_clean still pulses.
- UART FIFO: circular buffer, pointers one bit wider than log2(UART_DEPTH).
  - uart_full = count==UART_DEPTH.
  - uart_rd_ch is combinational: head entry if non-empty, else 8'hff.
  - Pop when uart_rd=1 and FIFO non-empty, in any state except RST_HOLD.
  - Push when uart_push=1 and (not full, or a pop occurs the same cycle). Simultaneous push+pop keeps count unchanged, order preserved.
  - Push while full with no pop: char dropped, uart_ovf set (sticky until reset).
  - Pushes are accepted in all states, including RST_HOLD.
- All outputs are registered except uart_rd_ch and uart_full (from registered count).

Test Plan:
1. RESET_CYCLES=4; reset low 3 cycles then high -> dut_reset high exactly 4 cycles; init_req rises the cycle dut_reset falls; held until init_ack on 3rd cycle; RUN next; perf_clean single pulse.
2. RUN, step_ack 10 of 15 cycles (irregular), then halt -> cycle_cnt=10; halted=1; step_req=0; later step_ack pulses leave cycle_cnt=10.
3. PERF_INTERVAL=3, continuous step_ack for 10 steps -> perf_dump pulses exactly after cycle_cnt reaches 3, 6, 9 (3 pulses); none at 0.
4. UART_DEPTH=4: push 'a','b','c','d','e' with no reads -> uart_full=1 after 4; 'e' dropped; uart_ovf=1. Four reads return 0x61..0x64; a fifth read returns 0xff with no underflow.
5. FIFO full plus simultaneous uart_push('z') and uart_rd -> read returns head; 'z' accepted; count stays 4; uart_ovf unchanged.
6. Reset asserted mid-RUN with cycle_cnt=57 and 2 chars queued -> next cycle: RST_HOLD, dut_reset=1, cycle_cnt=0, FIFO empty, uart_rd_ch=0xff. halt asserted during INIT -> HALTED after first RUN cycle with cycle_cnt=0.
